// File: rtl/int8_stim_loader_if.sv
// Memory-load port of the int8 dot-product test case (write strobe, address, data).
// The loader drives it through the master modport; the test case consumes the slave modport.
interface int8_stim_loader_if #(
   parameter int unsigned WIDTH      = 8,
   parameter int unsigned ADDR_WIDTH = 10
);
   logic                  write;
   logic [ADDR_WIDTH-1:0] addr;
   logic [WIDTH-1:0]      data_in;

   modport master (output write, output addr, output data_in);
   modport slave  (input write, input addr, input data_in);
endinterface

// File: rtl/int8_stim_loader.sv
// Fills NUM_INPUTS test-case words with LFSR pseudo-random data on a start pulse.
// Optional STIM_CHECKSUM_EN adds a signed running sum of the written words.
module int8_stim_loader #(
   parameter int unsigned WIDTH      = 8,
   parameter int unsigned NUM_INPUTS = 1024,
   parameter int unsigned ADDR_WIDTH = $clog2(NUM_INPUTS),
   parameter logic [15:0] SEED       = 16'hACE1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  hold,
   int8_stim_loader_if.master    ld,
   output logic                  busy,
   output logic                  done,
   output logic [ADDR_WIDTH:0]   words_written
`ifdef STIM_CHECKSUM_EN
   ,
   output logic signed [WIDTH+ADDR_WIDTH:0] checksum
`endif
);

   localparam int unsigned CntW = ADDR_WIDTH + 1;
   localparam logic [CntW-1:0] LastCnt  = CntW'(NUM_INPUTS - 1);
   localparam logic [CntW-1:0] NumWords = CntW'(NUM_INPUTS);
   localparam logic [CntW-1:0] CntOne   = CntW'(1);

   typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;

   state_e                state_q, state_d;
   logic [CntW-1:0]       cnt_q, cnt_d;
   logic [15:0]           lfsr_q, lfsr_d;
   logic                  write_q, write_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [WIDTH-1:0]      data_q, data_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic [CntW-1:0]       words_q, words_d;
   logic [WIDTH-1:0]      word;

   // Fibonacci LFSR, x^16 + x^14 + x^13 + x^11 + 1
   function automatic logic [15:0] lfsr_next(input logic [15:0] l);
      return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
   endfunction

   assign word = lfsr_q[WIDTH-1:0];

`ifdef STIM_CHECKSUM_EN
   localparam int unsigned SumW = WIDTH + ADDR_WIDTH + 1;
   logic signed [SumW-1:0]  sum_q, sum_d;
   logic signed [WIDTH-1:0] word_s;
   assign word_s = $signed(word);
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      lfsr_d  = lfsr_q;
      write_d = write_q;
      addr_d  = addr_q;
      data_d  = data_q;
      busy_d  = busy_q;
      done_d  = done_q;
      words_d = words_q;
`ifdef STIM_CHECKSUM_EN
      sum_d   = sum_q;
`endif
      unique case (state_q)
         StIdle: begin
            write_d = 1'b0;
         end
         StLoad: begin
            if (hold) begin
               write_d = 1'b0;
            end else begin
               write_d = 1'b1;
               addr_d  = cnt_q[ADDR_WIDTH-1:0];
               data_d  = word;
               cnt_d   = cnt_q + CntOne;
               lfsr_d  = lfsr_next(lfsr_q);
               if (words_q != NumWords) begin
                  words_d = words_q + CntOne;
               end
`ifdef STIM_CHECKSUM_EN
               sum_d = sum_q + SumW'(word_s);
`endif
               if (cnt_q == LastCnt) begin
                  state_d = StDone;
               end
            end
         end
         StDone: begin
            write_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
         end
         default: begin
            state_d = StIdle;
            write_d = 1'b0;
         end
      endcase

      // A new load restarts the identical sequence; start is ignored mid-load.
      if ((state_q == StIdle || state_q == StDone) && start) begin
         state_d = StLoad;
         cnt_d   = '0;
         lfsr_d  = SEED;
         words_d = '0;
         busy_d  = 1'b1;
         done_d  = 1'b0;
`ifdef STIM_CHECKSUM_EN
         sum_d   = '0;
`endif
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         lfsr_q  <= SEED;
         write_q <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         words_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         lfsr_q  <= lfsr_d;
         write_q <= write_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         words_q <= words_d;
      end
   end

`ifdef STIM_CHECKSUM_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sum_q <= '0;
      end else begin
         sum_q <= sum_d;
      end
   end

   assign checksum = sum_q;
`endif

   assign ld.write      = write_q;
   assign ld.addr       = addr_q;
   assign ld.data_in    = data_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign words_written = words_q;

endmodule

// File: tb/tb_int8_stim_loader.sv
// Bench for int8_stim_loader with NUM_INPUTS=4: cycle vector table plus write scoreboard.
// Checksum checks are compiled in when STIM_CHECKSUM_EN is defined.
module tb_int8_stim_loader;

   localparam int unsigned W  = 8;
   localparam int unsigned N  = 4;
   localparam int unsigned AW = 2;

   logic clk;
   logic reset;
   logic start;
   logic hold;
   logic busy;
   logic done;
   logic [AW:0] words_written;
`ifdef STIM_CHECKSUM_EN
   logic signed [W+AW:0] checksum;
`endif

   int8_stim_loader_if #(.WIDTH(W), .ADDR_WIDTH(AW)) ld ();

   int8_stim_loader #(
      .WIDTH(W),
      .NUM_INPUTS(N),
      .ADDR_WIDTH(AW),
      .SEED(16'hACE1)
   ) dut (
      .clk(clk),
      .reset(reset),
      .start(start),
      .hold(hold),
      .ld(ld),
      .busy(busy),
      .done(done),
      .words_written(words_written)
`ifdef STIM_CHECKSUM_EN
      ,
      .checksum(checksum)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Expected load sequence from SEED 16'hACE1
   logic [7:0] exp_words [4] = '{8'hE1, 8'hC3, 8'h87, 8'h0F};
   logic [AW+W-1:0] sb [$];

   typedef struct {
      logic       st;
      logic       hd;
      logic       w;
      logic [1:0] a;
      logic [7:0] d;
      logic       b;
      logic       dn;
      logic [2:0] ww;
   } vec_t;

   vec_t vecs [$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push_load();
      for (int i = 0; i < 4; i++) begin
         sb.push_back({2'(i), exp_words[i]});
      end
   endtask

   task automatic step(input logic s, input logic h);
      start = s;
      hold  = h;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk_out(input string tag, input logic w, input logic [1:0] a,
                          input logic [7:0] d, input logic b, input logic dn,
                          input logic [2:0] ww);
      chk({tag, "_write"}, 32'(ld.write), 32'(w));
      chk({tag, "_addr"}, 32'(ld.addr), 32'(a));
      chk({tag, "_data"}, 32'(ld.data_in), 32'(d));
      chk({tag, "_busy"}, 32'(busy), 32'(b));
      chk({tag, "_done"}, 32'(done), 32'(dn));
      chk({tag, "_words"}, 32'(words_written), 32'(ww));
   endtask

   // Scoreboard: every observed write must match the next expected (addr, data).
   always @(negedge clk) begin
      if (!reset && ld.write === 1'b1) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected_write: got addr %0h data %0h expected no write",
                     ld.addr, ld.data_in);
         end else begin
            chk("sb_write", 32'({ld.addr, ld.data_in}), 32'(sb.pop_front()));
         end
      end
   end

   initial begin
      reset = 1'b1;
      start = 1'b0;
      hold  = 1'b0;
      #1;
      chk_out("reset0", 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 3'd0);
`ifdef STIM_CHECKSUM_EN
      chk("reset0_checksum", 32'(checksum), 32'(0));
`endif
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;

      // hold in IDLE, basic load, hold in DONE
      vecs.push_back('{1'b0, 1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 3'd0});
      vecs.push_back('{1'b1, 1'b0, 1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 3'd0});
      vecs.push_back('{1'b0, 1'b0, 1'b1, 2'd0, 8'hE1, 1'b1, 1'b0, 3'd1});
      vecs.push_back('{1'b0, 1'b0, 1'b1, 2'd1, 8'hC3, 1'b1, 1'b0, 3'd2});
      vecs.push_back('{1'b0, 1'b0, 1'b1, 2'd2, 8'h87, 1'b1, 1'b0, 3'd3});
      vecs.push_back('{1'b0, 1'b0, 1'b1, 2'd3, 8'h0F, 1'b1, 1'b0, 3'd4});
      vecs.push_back('{1'b0, 1'b0, 1'b0, 2'd3, 8'h0F, 1'b0, 1'b1, 3'd4});
      vecs.push_back('{1'b0, 1'b1, 1'b0, 2'd3, 8'h0F, 1'b0, 1'b1, 3'd4});
      // reload from DONE, 2-cycle hold after the 2nd write
      vecs.push_back('{1'b1, 1'b0, 1'b0, 2'd3, 8'h0F, 1'b1, 1'b0, 3'd0});
      vecs.push_back('{1'b0, 1'b0, 1'b1, 2'd0, 8'hE1, 1'b1, 1'b0, 3'd1});
      vecs.push_back('{1'b0, 1'b0, 1'b1, 2'd1, 8'hC3, 1'b1, 1'b0, 3'd2});
      vecs.push_back('{1'b0, 1'b1, 1'b0, 2'd1, 8'hC3, 1'b1, 1'b0, 3'd2});
      vecs.push_back('{1'b0, 1'b1, 1'b0, 2'd1, 8'hC3, 1'b1, 1'b0, 3'd2});
      vecs.push_back('{1'b0, 1'b0, 1'b1, 2'd2, 8'h87, 1'b1, 1'b0, 3'd3});
      vecs.push_back('{1'b0, 1'b0, 1'b1, 2'd3, 8'h0F, 1'b1, 1'b0, 3'd4});
      vecs.push_back('{1'b0, 1'b0, 1'b0, 2'd3, 8'h0F, 1'b0, 1'b1, 3'd4});
      // hold on the final word defers it
      vecs.push_back('{1'b1, 1'b0, 1'b0, 2'd3, 8'h0F, 1'b1, 1'b0, 3'd0});
      vecs.push_back('{1'b0, 1'b0, 1'b1, 2'd0, 8'hE1, 1'b1, 1'b0, 3'd1});
      vecs.push_back('{1'b0, 1'b0, 1'b1, 2'd1, 8'hC3, 1'b1, 1'b0, 3'd2});
      vecs.push_back('{1'b0, 1'b0, 1'b1, 2'd2, 8'h87, 1'b1, 1'b0, 3'd3});
      vecs.push_back('{1'b0, 1'b1, 1'b0, 2'd2, 8'h87, 1'b1, 1'b0, 3'd3});
      vecs.push_back('{1'b0, 1'b0, 1'b1, 2'd3, 8'h0F, 1'b1, 1'b0, 3'd4});
      vecs.push_back('{1'b0, 1'b0, 1'b0, 2'd3, 8'h0F, 1'b0, 1'b1, 3'd4});

      for (int i = 0; i < vecs.size(); i++) begin
         if (vecs[i].st) push_load();
         step(vecs[i].st, vecs[i].hd);
         chk_out($sformatf("vec%0d", i), vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].b,
                 vecs[i].dn, vecs[i].ww);
      end
`ifdef STIM_CHECKSUM_EN
      chk("done_checksum", 32'(checksum), 32'(-198));
`endif

      // start and hold together in IDLE: LOAD entered, first write waits for hold=0
      reset = 1'b1;
      #1;
      chk_out("rst1", 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 3'd0);
      sb.delete();
      @(negedge clk);
      reset = 1'b0;
      push_load();
      step(1'b1, 1'b1);
      chk_out("sh_enter", 1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 3'd0);
      step(1'b0, 1'b1);
      chk_out("sh_wait", 1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 3'd0);
      step(1'b0, 1'b0);
      chk_out("sh_first", 1'b1, 2'd0, 8'hE1, 1'b1, 1'b0, 3'd1);
      for (int i = 1; i < 4; i++) step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      chk_out("sh_done", 1'b0, 2'd3, 8'h0F, 1'b0, 1'b1, 3'd4);

      // reset mid-load aborts immediately, next start replays from the seed
      push_load();
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      chk_out("ml_second", 1'b1, 2'd1, 8'hC3, 1'b1, 1'b0, 3'd2);
      #2;
      reset = 1'b1;
      #1;
      chk_out("ml_reset", 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 3'd0);
`ifdef STIM_CHECKSUM_EN
      chk("ml_reset_checksum", 32'(checksum), 32'(0));
`endif
      sb.delete();
      @(negedge clk);
      reset = 1'b0;
      push_load();
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      chk_out("ml_replay", 1'b1, 2'd0, 8'hE1, 1'b1, 1'b0, 3'd1);
      for (int i = 1; i < 4; i++) step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      chk_out("ml_done", 1'b0, 2'd3, 8'h0F, 1'b0, 1'b1, 3'd4);

      // start held high through LOAD: no restart, then immediate reload from DONE
      push_load();
      step(1'b1, 1'b0);
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 1'b0);
         chk_out($sformatf("sk_w%0d", i), 1'b1, 2'(i), exp_words[i], 1'b1, 1'b0, 3'(i + 1));
      end
      push_load();
      step(1'b1, 1'b0);
      chk_out("sk_reload", 1'b0, 2'd3, 8'h0F, 1'b1, 1'b0, 3'd0);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      chk_out("sk_done", 1'b0, 2'd3, 8'h0F, 1'b0, 1'b1, 3'd4);
`ifdef STIM_CHECKSUM_EN
      chk("sk_checksum", 32'(checksum), 32'(-198));
`endif

      step(1'b0, 1'b0);
      chk("sb_empty", 32'(sb.size()), 32'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/int8_stim_loader.md
Name: int8_stim_loader

Overview:
- Upstream stimulus stage for the int8 dot-product test case. Drives the test case's `write`/`addr`/`data_in` memory-load port.
- On a `start` pulse, fills all NUM_INPUTS addresses with pseudo-random signed int8 words from a 16-bit LFSR, then reports done.
- Lets the board-level top load real data before the MACCs run, replacing the tied-off constant write port.

Parameters:
- WIDTH, 8, data word width; must be ≤ 16.
- NUM_INPUTS, 1024, number of words written per load (addresses 0..NUM_INPUTS-1).
- ADDR_WIDTH, $clog2(NUM_INPUTS), width of `addr`.
- SEED, 16'hACE1, LFSR reset/reload value; must be nonzero.

Ports:
- clk  input  1  system clock (PLL output).
- reset  input  1  asynchronous, active-high reset (driven from ~locked at top).
- start  input  1  begin a load; level-sampled, acted on only in IDLE or DONE.
- hold  input  1  stall; while high in LOAD, no write is issued and the sequence freezes.
- write  output  1  registered write strobe to test case.
- addr  output  ADDR_WIDTH  registered write address.
- data_in  output  WIDTH  registered write data (two's complement).
- busy  output  1  high while in LOAD.
- done  output  1  high while in DONE.
- words_written  output  ADDR_WIDTH+1  count of writes issued in the current/last load.

Behaviour:
- Reset (async, active-high) forces these values immediately:
  - state=IDLE.
  - write=0, addr=0, data_in=0.
  - busy=0, done=0, words_written=0.
  - internal cnt=0, lfsr=SEED.
- LFSR: Fibonacci, polynomial x^16+x^14+x^13+x^11+1.
  - fb = l[15]^l[13]^l[12]^l[10].
  - next = {l[14:0], fb}.
  - Word data = l[WIDTH-1:0] of the current value, before advancing.
- FSM states: IDLE, LOAD, DONE.
  - IDLE: start=1 at an edge → LOAD. cnt=0, lfsr=SEED, words_written=0, busy=1.
  - LOAD, edge with hold=0:
    - write<=1, addr<=cnt, data_in<=lfsr[WIDTH-1:0].
    - cnt++, lfsr advances, words_written++.
    - If cnt==NUM_INPUTS-1 at that edge → DONE.
  - LOAD, edge with hold=1: write<=0; addr, data_in, cnt, lfsr and words_written all hold.
  - LOAD: start is ignored.
  - DONE: write<=0, busy=0, done=1, addr and data_in hold their last values.
    - start=1 → LOAD with the same reload as from IDLE; done clears.
    - The identical sequence repeats, so loads are deterministic.
- Latency and counts:
  - start sampled at edge k → first write visible after edge k+1 (if hold=0).
  - With no hold, the last write is visible after edge k+NUM_INPUTS.
  - write falls and done rises after edge k+NUM_INPUTS+1.
  - Exactly NUM_INPUTS writes per load, addresses strictly increasing 0..NUM_INPUTS-1, with no duplicates and no wrap.
- Boundary conditions:
  - hold on the final word: the final write is deferred, not dropped.
  - hold in IDLE or DONE: no effect.
  - start and hold high together in IDLE: the state enters LOAD; the first write waits for hold=0.
  - reset mid-LOAD: aborts immediately to reset values; no partial-write retention.
- Arithmetic:
  - cnt is ADDR_WIDTH+1 bits internally, so NUM_INPUTS equal to a power of two does not overflow.
  - words_written saturates at NUM_INPUTS.

Optional Feature:
- Macro: STIM_CHECKSUM_EN.
- Defined:
  - Adds output `checksum`, signed, WIDTH+ADDR_WIDTH+1 bits.
  - Reset and each load start clear it to 0.
  - On every issued write it accumulates sign-extended data_in, registered and updated on the same edge as write.
  - Final value is valid while done=1.
  - Lets the top compare against the test case's sum.
- Undefined: no port and no accumulator logic; all other behaviour is identical.

Test Plan:
- Reset then start pulse, NUM_INPUTS=4:
  - writes are (addr 0, 0xE1), (1, 0xC3), (2, 0x87), (3, 0x0F) on 4 consecutive cycles after start+1;
  - then write=0, done=1, words_written=4.
- Same with hold=1 for 2 cycles after the 2nd write:
  - write=0 for exactly those cycles, addr/data frozen at (1, 0xC3);
  - resumes with (2, 0x87); total 4 writes.
- Assert reset after the 2nd write:
  - all outputs 0 immediately;
  - a new start replays from (0, 0xE1).
- In DONE, pulse start: identical 4-write sequence repeats, done clears the cycle LOAD is entered.
- start held high throughout LOAD: no restart or duplicate; exactly 4 writes, then immediate reload from DONE.
- STIM_CHECKSUM_EN defined, NUM_INPUTS=4: checksum = -31-61-121+15 = -198 when done=1; 0 after reset.
